uart_tx_controller: RTL and testbench



---
 rtl/uart_tx_controller.sv | 108 ++++++++++
 tb/tb_uart_tx_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: memory-mapped 8N1 UART transmitter with a transmit FIFO, status/baud registers and a done interrupt.
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ren,
    input  logic        wen,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        uart_tx,
    output logic        tx_done_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_next;
    logic [7:0]       shift;
    logic [2:0]       idx;
    logic [CNT_W-1:0] divisor, act_div, cnt;
    logic             overflow, full, empty, push_req, push, pop, tc, irq_next;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign unused_bits = ^data_in;

    always_comb begin
        full       = count == (AW+1)'(FIFO_DEPTH);
        empty      = count == '0;
        push_req   = wen && address == 2'd0;
        pop        = state == IDLE && !empty;
        push       = push_req && (!full || pop);
        tc         = cnt == act_div - 1'b1;
        count_next = count + (AW+1)'(push) - (AW+1)'(pop);
        // interrupt is registered from next-cycle state so it drops right after a push
        irq_next   = count_next == '0 && ((state == IDLE && !pop) || (state == STOP && tc));
        rdata      = address == 2'd1 ? {16'd0, 8'(count), 4'd0, overflow, empty, full, state != IDLE}
                   : address == 2'd2 ? 32'(divisor) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            shift       <= '0;
            idx         <= '0;
            cnt         <= '0;
            divisor     <= CNT_W'(CLKS_PER_BIT);
            act_div     <= CNT_W'(CLKS_PER_BIT);
            overflow    <= 1'b0;
            data_out    <= '0;
            uart_tx     <= 1'b1;
            tx_done_irq <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (wen && address == 2'd1 && data_in[3]) overflow <= 1'b0;
            if (wen && address == 2'd2)
                divisor <= data_in[CNT_W-1:0] < CNT_W'(4) ? CNT_W'(4) : data_in[CNT_W-1:0];
            if (ren) data_out <= rdata;
            tx_done_irq <= irq_next;
            // line follows the state one cycle late, giving a glitch-free registered output
            uart_tx <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
            case (state)
                IDLE: if (pop) begin
                    shift   <= mem[rd_ptr];
                    act_div <= divisor;
                    cnt     <= '0;
                    state   <= START;
                end
                START: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        state <= DATA;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        shift <= shift >> 1;
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) state <= STOP;
                    end
                end
                default: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: directed bench with a byte scoreboard checked by a serial-line frame monitor.
module tb_uart_tx_controller;
    logic        clk = 1'b0, resetn = 1'b0, ren = 1'b0, wen = 1'b0;
    logic [1:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        uart_tx, tx_done_irq;
    int          checks = 0, errors = 0, cyc = 0, frames_done = 0, model_div = 4;
    logic [7:0]  sb [$];

    uart_tx_controller #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .resetn(resetn), .ren(ren), .wen(wen), .address(address),
        .data_in(data_in), .data_out(data_out), .uart_tx(uart_tx), .tx_done_irq(tx_done_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
        ren = r; wen = w; address = a; data_in = d;
        @(negedge clk);
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        op(1'b1, 1'b0, a, 32'd0);
        v = data_out;
    endtask

    task automatic push_byte(input logic [7:0] b);
        op(1'b0, 1'b1, 2'd0, {24'd0, b});
        sb.push_back(b);
    endtask

    task automatic wait_until(input int target);
        for (int k = 0; k < 5000 && cyc < target; k++) @(negedge clk);
        check("wait_cycle", 32'(cyc), 32'(target));
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 5000 && frames_done < n; k++) @(negedge clk);
        check("frames_done", 32'(frames_done), 32'(n));
    endtask

    // Monitor: checks every cycle of each frame against the next scoreboard byte
    initial begin : mon
        logic [7:0] eb;
        logic [9:0] frame, obs;
        logic       ok, aborted;
        int         d;
        forever begin
            @(negedge clk);
            if (resetn && uart_tx === 1'b0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_start: observed start bit expected idle line");
                end
                eb = sb.size() != 0 ? sb.pop_front() : 8'h00;
                d = model_div;
                frame = {1'b1, eb, 1'b0};
                obs = '0;
                ok = 1'b1;
                aborted = 1'b0;
                for (int j = 0; j < 10 * d; j++) begin
                    if (j > 0) @(negedge clk);
                    if (!resetn) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (uart_tx !== frame[j / d]) ok = 1'b0;
                    if (j % d == d / 2) obs[j / d] = uart_tx;
                end
                if (!aborted) begin
                    checks++;
                    assert (ok && obs === frame) else begin
                        errors++;
                        $error("FAIL frame: observed %b (timing ok=%0b) expected %b", obs, ok, frame);
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] v;
        int n, f0;
        repeat (2) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(tx_done_irq), 32'd1);
        check("rst_data_out", data_out, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        rd(2'd1, v); check("rst_status", v, 32'h0000_0004);
        rd(2'd2, v); check("rst_baud", v, 32'd4);
        rd(2'd0, v); check("txdata_reads_0", v, 32'd0);
        rd(2'd3, v); check("reserved_reads_0", v, 32'd0);

        // single frame 0xA5 and its latency
        n = cyc + 1;
        push_byte(8'hA5);
        check("irq_after_push", 32'(tx_done_irq), 32'd0);
        rd(2'd1, v); check("status_after_push", v, 32'h0000_0100);
        check("tx_high_n1", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check("tx_low_n2", 32'(uart_tx), 32'd0);
        rd(2'd1, v); check("status_sending", v, 32'h0000_0005);
        wait_frames(1);
        check("irq_after_frame", 32'(tx_done_irq), 32'd1);

        // 17 back-to-back bytes, overflow, clear, push-while-full-and-popping
        n = cyc + 1;
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        rd(2'd1, v); check("status_full", v, 32'h0000_1003);
        op(1'b0, 1'b1, 2'd0, 32'hEE);
        rd(2'd1, v); check("status_overflow", v, 32'h0000_100B);
        op(1'b0, 1'b1, 2'd1, 32'h8);
        rd(2'd1, v); check("status_ovf_clear", v, 32'h0000_1003);
        wait_until(n + 41);
        push_byte(8'h55);
        rd(2'd1, v); check("status_push_pop_full", v, 32'h0000_1003);
        wait_frames(19);

        // baud change mid-frame applies to the next frame only
        n = cyc + 1;
        push_byte(8'h11);
        push_byte(8'h22);
        wait_until(n + 11);
        op(1'b0, 1'b1, 2'd2, 32'd8);
        model_div = 8;
        rd(2'd2, v); check("baud_8", v, 32'd8);
        wait_frames(21);
        op(1'b0, 1'b1, 2'd2, 32'd1);
        model_div = 4;
        rd(2'd2, v); check("baud_clamp", v, 32'd4);
        op(1'b1, 1'b1, 2'd2, 32'd6);
        check("rw_pre_write", data_out, 32'd4);
        rd(2'd2, v); check("rw_post_write", v, 32'd6);
        op(1'b0, 1'b1, 2'd2, 32'd4);

        // reset during data bit 3 of 0x3C with two bytes queued
        n = cyc + 1;
        push_byte(8'h3C);
        push_byte(8'hAA);
        push_byte(8'hBB);
        wait_until(n + 18);
        resetn = 1'b0;
        #1;
        check("abort_uart_tx", 32'(uart_tx), 32'd1);
        check("abort_irq", 32'(tx_done_irq), 32'd1);
        sb.delete();
        f0 = frames_done;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rd(2'd1, v); check("abort_status", v, 32'h0000_0004);
        rd(2'd2, v); check("abort_baud", v, 32'd4);
        v = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) v++;
        end
        check("no_start_after_abort", v, 32'd0);
        check("no_frames_after_abort", 32'(frames_done), 32'(f0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
